// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// the fixed fetch access size and a small state helper.
package mem_arb_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_FETCH = 2'd1;
    localparam logic [1:0] ARB_DATA  = 2'd2;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    // True while an access is being held on the memory port.
    function automatic logic arb_busy(input logic [1:0] state);
        return (state == ARB_FETCH) || (state == ARB_DATA);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side hold-until-ready bus. The arbiter is the master; the memory
// model is the slave.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction
// fetch and MEM-stage data accesses. Data has priority; a redirect kills
// the in-flight fetch; stall freezes the pipeline while either side waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               if_req,
    input  logic [AW-1:0]      if_addr,
    input  logic               if_flush,
    output logic               if_valid,
    output logic [DW-1:0]      if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [2:0]         d_funct3,
    input  logic [AW-1:0]      d_addr,
    input  logic [DW-1:0]      d_wdata,
    output logic               d_done,
    output logic [DW-1:0]      d_rdata,
    mem_port_arbiter_if.master mem,
    output logic               stall
);

    logic [1:0]    state_q,    state_d;
    logic          kill_q,     kill_d;
    logic          we_q,       we_d;
    logic [2:0]    funct3_q,   funct3_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_done_q,   d_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q,  d_rdata_d;

    // A requester whose completion pulse is high this cycle is still showing
    // the request that just finished; it only presents a new one next cycle,
    // so it must not be re-issued now.
    logic d_take;
    logic f_take;
    assign d_take = d_req  & ~d_done_q;
    assign f_take = if_req & ~if_valid_q;

    // Next-state logic: arbitration in IDLE, hold-until-ready otherwise.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_done_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (d_take) begin
                    // Data belongs to the older instruction and always wins.
                    state_d  = ARB_DATA;
                    we_d     = d_we;
                    funct3_d = d_funct3;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                end else if (f_take) begin
                    state_d  = ARB_FETCH;
                    we_d     = 1'b0;
                    funct3_d = FUNCT3_WORD;
                    addr_d   = if_addr;
                    // A redirect on the issue cycle makes this fetch stale.
                    kill_d   = if_flush;
                end
            end
            ARB_FETCH: begin
                if (mem.mem_ready) begin
                    state_d = ARB_IDLE;
                    kill_d  = 1'b0;
                    // A flush coinciding with ready also discards the fetch.
                    if (!(kill_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem.mem_rdata;
                    end
                end else if (if_flush) begin
                    kill_d = 1'b1;
                end
            end
            ARB_DATA: begin
                // Data accesses are never cancelled by a redirect.
                if (mem.mem_ready) begin
                    state_d   = ARB_IDLE;
                    d_done_d  = 1'b1;
                    d_rdata_d = mem.mem_rdata;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State, request latch and response registers; reset aborts any access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            kill_q     <= 1'b0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_valid_q <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_valid_q <= if_valid_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem.mem_req    = arb_busy(state_q);
    assign mem.mem_we     = we_q;
    assign mem.mem_funct3 = funct3_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = wdata_q;

    assign if_valid = if_valid_q;
    assign if_rdata = if_rdata_q;
    assign d_done   = d_done_q;
    assign d_rdata  = d_rdata_q;

    // Pipeline freezes while any requester is still waiting for its pulse.
    assign stall = d_take | f_take;

endmodule
